// File: rtl/gdiv_pkg.sv
// gdiv_mc shared types: counter type, default INIT, update decision.
// Imported by gdiv_lane and gdiv_mc.
package gdiv_pkg;

  localparam int GDIV_DEP = 5;

  typedef logic [GDIV_DEP-1:0] cnt_t;

  typedef enum logic [1:0] {
    HOLD,
    INC,
    DEC
  } upd_e;

  function automatic int init_default(input int dep);
    return 2 ** (dep - 1);
  endfunction

endpackage

// File: rtl/gdiv_lane.sv
// gdiv_mc lane: saturating up/down counter, divisor delay,
// update decision and sticky saturation flags.
module gdiv_lane
  import gdiv_pkg::*;
#(
  parameter int DEP  = GDIV_DEP,
  parameter int INIT = init_default(GDIV_DEP)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           en,
  input  logic [DEP-1:0] rnd,
  input  logic           dividend,
  input  logic           divisor,
  output logic           q,
  output logic           sat_hi,
  output logic           sat_lo
);

  localparam logic [DEP-1:0] INIT_V = DEP'(INIT);
  localparam logic [DEP-1:0] MAX_V  = '1;
  localparam logic [DEP-1:0] ONE_V  = DEP'(1);
  localparam logic [DEP-1:0] NF_V   = MAX_V - ONE_V;

  logic [DEP-1:0] cnt;
  logic           div_d;
  logic           x0;
  logic           x1;
  logic           x2;
  logic           inc;
  logic           dec;
  logic           full;
  logic           empty;
  upd_e           upd;

  assign q     = (cnt > rnd);
  assign x0    = ~(divisor ^ div_d);
  assign x1    = ~(divisor ^ dividend);
  assign x2    = ~(x0 ^ ~q);
  assign inc   = x1 & x2;
  assign dec   = ~x1 & ~x2;
  assign full  = (cnt == MAX_V);
  assign empty = (cnt == '0);

  always_comb begin
    upd = HOLD;
    if (inc && !full) begin
      upd = INC;
    end else if (dec && !empty) begin
      upd = DEC;
    end
  end

  // Flags set only on the transition into the rail, not on holding there.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt    <= INIT_V;
      div_d  <= 1'b0;
      sat_hi <= 1'b0;
      sat_lo <= 1'b0;
    end else if (en) begin
      div_d <= divisor;
      unique case (upd)
        INC: begin
          cnt <= cnt + ONE_V;
          if (cnt == NF_V) sat_hi <= 1'b1;
        end
        DEC: begin
          cnt <= cnt - ONE_V;
          if (cnt == ONE_V) sat_lo <= 1'b1;
        end
        default: begin
          cnt <= cnt;
        end
      endcase
    end
  end

endmodule

// File: rtl/gdiv_mc.sv
// Multi-lane stochastic divider with stream-length counter.
// GDIV_MC_QREG_EN: register the quotient port (1 cycle latency).
module gdiv_mc
  import gdiv_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int DEP   = GDIV_DEP,
  parameter int INIT  = init_default(DEP),
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [LEN_W-1:0] len,
  input  logic [DEP-1:0]   randNum,
  input  logic [NCH-1:0]   dividend,
  input  logic [NCH-1:0]   divisor,
  output logic [NCH-1:0]   quotient,
  output logic [NCH-1:0]   sat_hi,
  output logic [NCH-1:0]   sat_lo,
  output logic             done
);

  logic [NCH-1:0]   q;
  logic [LEN_W-1:0] len_cnt;

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    gdiv_lane #(
      .DEP (DEP),
      .INIT(INIT)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .en      (en),
      .rnd     (randNum),
      .dividend(dividend[i]),
      .divisor (divisor[i]),
      .q       (q[i]),
      .sat_hi  (sat_hi[i]),
      .sat_lo  (sat_lo[i])
    );
  end

  // A len lowered below len_cnt lets the counter wrap silently.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      len_cnt <= '0;
      done    <= 1'b0;
    end else if (en) begin
      if (len_cnt == len) begin
        len_cnt <= '0;
        done    <= 1'b1;
      end else begin
        len_cnt <= len_cnt + 1'b1;
        done    <= 1'b0;
      end
    end else begin
      done <= 1'b0;
    end
  end

`ifdef GDIV_MC_QREG_EN
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      quotient <= '0;
    end else begin
      quotient <= q;
    end
  end
`else
  assign quotient = q;
`endif

endmodule

// File: tb/tb_gdiv_mc.sv
// Self-checking bench for gdiv_mc against a behavioural model.
// Honors GDIV_MC_QREG_EN for the expected quotient latency.
module tb_gdiv_mc;

  localparam int NCH   = 4;
  localparam int DEP   = 5;
  localparam int LEN_W = 8;
  localparam int INIT  = 16;
  localparam int MAXC  = 31;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             clr = 1'b0;
  logic [LEN_W-1:0] len = '1;
  logic [DEP-1:0]   randNum = '0;
  logic [NCH-1:0]   dividend = '0;
  logic [NCH-1:0]   divisor = '0;
  logic [NCH-1:0]   quotient;
  logic [NCH-1:0]   sat_hi;
  logic [NCH-1:0]   sat_lo;
  logic             done;

  gdiv_mc #(
    .NCH  (NCH),
    .DEP  (DEP),
    .INIT (INIT),
    .LEN_W(LEN_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .clr     (clr),
    .len     (len),
    .randNum (randNum),
    .dividend(dividend),
    .divisor (divisor),
    .quotient(quotient),
    .sat_hi  (sat_hi),
    .sat_lo  (sat_lo),
    .done    (done)
  );

  always #5 clk = ~clk;

  logic [DEP-1:0]   o_cnt[NCH];
  logic [LEN_W-1:0] o_len;
  assign o_cnt[0] = dut.g_lane[0].u_lane.cnt;
  assign o_cnt[1] = dut.g_lane[1].u_lane.cnt;
  assign o_cnt[2] = dut.g_lane[2].u_lane.cnt;
  assign o_cnt[3] = dut.g_lane[3].u_lane.cnt;
  assign o_len = dut.len_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int             m_cnt[NCH];
  bit             m_dd[NCH];
  logic [NCH-1:0] m_hi;
  logic [NCH-1:0] m_lo;
  logic [NCH-1:0] m_qreg;
  int             m_len;
  bit             m_done;

  function automatic logic [NCH-1:0] m_q();
    logic [NCH-1:0] r;
    for (int i = 0; i < NCH; i++) r[i] = (m_cnt[i] > int'(randNum));
    return r;
  endfunction

  function automatic logic [NCH-1:0] exp_quot();
`ifdef GDIV_MC_QREG_EN
    return m_qreg;
`else
    return m_q();
`endif
  endfunction

  // Model: counter moves toward agreement of divisor and dividend,
  // steered by whether the divisor changed and the current quotient.
  task automatic step();
    logic [NCH-1:0] qpre;
    bit same, eq, q;
    qpre = m_q();
    @(posedge clk);
    cyc++;
    if (rst || clr) begin
      for (int i = 0; i < NCH; i++) begin
        m_cnt[i] = INIT;
        m_dd[i] = 0;
      end
      m_hi = '0; m_lo = '0; m_len = 0; m_done = 0; m_qreg = '0;
    end else begin
      m_qreg = qpre;
      if (en) begin
        for (int i = 0; i < NCH; i++) begin
          q = qpre[i];
          same = (divisor[i] == m_dd[i]);
          eq = (dividend[i] == divisor[i]);
          if (eq && (same != q) && m_cnt[i] < MAXC) begin
            m_cnt[i]++;
            if (m_cnt[i] == MAXC) m_hi[i] = 1'b1;
          end else if (!eq && (same == q) && m_cnt[i] > 0) begin
            m_cnt[i]--;
            if (m_cnt[i] == 0) m_lo[i] = 1'b1;
          end
          m_dd[i] = divisor[i];
        end
        if (m_len == int'(len)) begin
          m_len = 0; m_done = 1;
        end else begin
          m_len = (m_len + 1) % (1 << LEN_W); m_done = 0;
        end
      end else begin
        m_done = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1; clr = 0; en = 0;
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    randNum = '0;
    do_reset();
    for (int i = 0; i < NCH; i++) begin
      checks++;
      if (o_cnt[i] !== DEP'(INIT)) begin
        failures++;
        $display("FAIL reset_cnt%0d got=%0d exp=%0d", i, o_cnt[i], INIT);
      end
    end
    checks++;
    if ({sat_hi, sat_lo, done, o_len} !== '0) begin
      failures++;
      $display("FAIL reset_state hi=%b lo=%b done=%b len=%0d exp=0",
               sat_hi, sat_lo, done, o_len);
    end
    checks++;
    if (quotient !== exp_quot()) begin
      failures++;
      $display("FAIL reset_quot got=%b exp=%b", quotient, exp_quot());
    end
  endtask

  task automatic test_lanes();
    do_reset();
    en = 1; len = '1; randNum = '0;
    for (int k = 1; k <= 20; k++) begin
      dividend = {1'($urandom), ~k[0], 1'b0, 1'b1};
      divisor  = {1'($urandom), ~k[0], 1'b1, 1'b1};
      dividend[2] = k[0];
      divisor[2] = k[0];
      step();
      for (int i = 0; i < NCH; i++) begin
        checks++;
        if (o_cnt[i] !== DEP'(m_cnt[i])) begin
          failures++;
          $display("FAIL lanes_cnt%0d k=%0d got=%0d exp=%0d",
                   i, k, o_cnt[i], m_cnt[i]);
        end
      end
      checks++;
      if ({quotient, sat_hi, sat_lo} !== {exp_quot(), m_hi, m_lo}) begin
        failures++;
        $display("FAIL lanes_out k=%0d got=%b/%b/%b exp=%b/%b/%b", k,
                 quotient, sat_hi, sat_lo, exp_quot(), m_hi, m_lo);
      end
      if (k == 1) begin
        checks++;
        if (o_cnt[0] !== 5'd17) begin
          failures++;
          $display("FAIL pinned_c1 got=%0d exp=17", o_cnt[0]);
        end
      end
      if (k == 15) begin
        checks++;
        if (o_cnt[2] !== 5'd31 || sat_hi[2] !== 1'b1) begin
          failures++;
          $display("FAIL fill_15 got=%0d/%b exp=31/1", o_cnt[2], sat_hi[2]);
        end
      end
      if (k == 17 || k == 20) begin
        checks++;
        if (o_cnt[1] !== 5'd0 || sat_lo[1] !== 1'b1 ||
            o_cnt[0] !== 5'd17 || sat_hi[0] !== 1'b0 || sat_lo[0] !== 1'b0) begin
          failures++;
          $display("FAIL drain_pin k=%0d got=%0d/%b/%0d exp=0/1/17",
                   k, o_cnt[1], sat_lo[1], o_cnt[0]);
        end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    en = 1; len = '1; randNum = '0;
    dividend = '0; divisor = '1;
    repeat (9) step();
    checks++;
    if (o_cnt[1] !== 5'd8 || o_len !== 8'd9) begin
      failures++;
      $display("FAIL stall_pre got=%0d/%0d exp=8/9", o_cnt[1], o_len);
    end
    en = 0;
    for (int k = 0; k < 5; k++) begin
      randNum = (k % 2 == 0) ? 5'd5 : 5'd10;
      step();
      checks++;
      if (o_cnt[1] !== 5'd8 || o_len !== 8'd9 || sat_lo[1] !== 1'b0 ||
          done !== 1'b0 || quotient[1] !== (k % 2 == 0)) begin
        failures++;
        $display("FAIL stall_frz k=%0d got=%0d/%0d/%b/%b q=%b",
                 k, o_cnt[1], o_len, sat_lo[1], done, quotient[1]);
      end
    end
    randNum = '0; en = 1;
    repeat (7) step();
    checks++;
    if (o_cnt[1] !== 5'd1 || sat_lo[1] !== 1'b0) begin
      failures++;
      $display("FAIL stall_r7 got=%0d/%b exp=1/0", o_cnt[1], sat_lo[1]);
    end
    step();
    checks++;
    if (o_cnt[1] !== 5'd0 || sat_lo[1] !== 1'b1) begin
      failures++;
      $display("FAIL stall_r8 got=%0d/%b exp=0/1", o_cnt[1], sat_lo[1]);
    end
  endtask

  task automatic test_length();
    do_reset();
    en = 1; len = 8'd3;
    for (int k = 1; k <= 10; k++) begin
      randNum = DEP'($urandom);
      dividend = NCH'($urandom);
      divisor = NCH'($urandom);
      step();
      checks++;
      if (done !== (k == 4 || k == 8) || o_len !== LEN_W'(m_len)) begin
        failures++;
        $display("FAIL len_done k=%0d got=%b/%0d exp=%b/%0d",
                 k, done, o_len, (k == 4 || k == 8), m_len);
      end
    end
    clr = 1; en = 0;
    step();
    clr = 0;
    for (int i = 0; i < NCH; i++) begin
      checks++;
      if (o_cnt[i] !== DEP'(INIT)) begin
        failures++;
        $display("FAIL clr_cnt%0d got=%0d exp=%0d", i, o_cnt[i], INIT);
      end
    end
    checks++;
    if ({sat_hi, sat_lo, done, o_len} !== '0) begin
      failures++;
      $display("FAIL clr_state hi=%b lo=%b done=%b len=%0d exp=0",
               sat_hi, sat_lo, done, o_len);
    end
  endtask

  task automatic test_wrap();
    int bad;
    do_reset();
    en = 1; len = 8'd10;
    repeat (6) step();
    len = 8'd2;
    bad = 0;
    for (int k = 0; k < 250; k++) begin
      step();
      if (done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || o_len !== 8'd0) begin
      failures++;
      $display("FAIL wrap_run got_pulses=%0d len=%0d exp=0/0", bad, o_len);
    end
    repeat (2) step();
    checks++;
    if (done !== 1'b0 || o_len !== 8'd2) begin
      failures++;
      $display("FAIL wrap_pre got=%b/%0d exp=0/2", done, o_len);
    end
    step();
    checks++;
    if (done !== 1'b1 || o_len !== 8'd0) begin
      failures++;
      $display("FAIL wrap_done got=%b/%0d exp=1/0", done, o_len);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 63) == 0);
      clr = ($urandom_range(0, 31) == 0);
      en = ($urandom_range(0, 3) != 0);
      len = LEN_W'($urandom_range(0, 7));
      randNum = DEP'($urandom);
      dividend = NCH'($urandom);
      divisor = NCH'($urandom);
      if (k % 100 < 40) dividend = divisor;
      step();
      for (int i = 0; i < NCH; i++) begin
        checks++;
        if (o_cnt[i] !== DEP'(m_cnt[i])) begin
          failures++;
          $display("FAIL rnd_cnt%0d k=%0d got=%0d exp=%0d",
                   i, k, o_cnt[i], m_cnt[i]);
        end
      end
      checks++;
      if ({quotient, sat_hi, sat_lo, done, o_len} !==
          {exp_quot(), m_hi, m_lo, m_done, LEN_W'(m_len)}) begin
        failures++;
        $display("FAIL rnd_out k=%0d got=%b/%b/%b/%b/%0d exp=%b/%b/%b/%b/%0d",
                 k, quotient, sat_hi, sat_lo, done, o_len,
                 exp_quot(), m_hi, m_lo, m_done, m_len);
      end
    end
    rst = 0; clr = 0;
  endtask

`ifdef GDIV_MC_QREG_EN
  task automatic test_qreg();
    do_reset();
    en = 1; randNum = 5'd20;
    for (int k = 1; k <= 6; k++) begin
      divisor = {NCH{k[0]}};
      dividend = divisor;
      step();
    end
    rst = 1;
    step();
    rst = 0;
    checks++;
    if (quotient !== '0 || o_cnt[2] !== DEP'(INIT)) begin
      failures++;
      $display("FAIL qreg_rst got=%b/%0d exp=0/%0d", quotient, o_cnt[2], INIT);
    end
    randNum = '0;
    step();
    checks++;
    if (quotient !== {NCH{1'b1}}) begin
      failures++;
      $display("FAIL qreg_lat got=%b exp=1111", quotient);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lanes();
    test_stall();
    test_length();
    test_wrap();
    test_random();
`ifdef GDIV_MC_QREG_EN
    test_qreg();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
